// File: rtl/sum_checker_pkg.sv
// Shared types and helpers for the sum checker.
package sum_checker_pkg;

    // Checker FSM states.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSync   = 2'd1,
        StLocked = 2'd2
    } state_t;

    // Two lock-stepped counters summed: the adder output is always twice the model count.
    // Works on a 32-bit count so any WIDTH up to 32 can use it with zero-extension.
    function automatic logic [32:0] expected_obs(input logic [31:0] count);
        return {count, 1'b0};
    endfunction

endpackage

// File: rtl/sum_checker_sat_counter.sv
// Saturating up-counter used for the checker statistics.
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] value
);

    logic [CNT_WIDTH-1:0] value_q;
    logic [CNT_WIDTH-1:0] value_d;

    // Increment unless already at all-ones.
    always_comb begin
        value_d = value_q;
        if (inc && (value_q != '1)) begin
            value_d = value_q + CNT_WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/sum_checker.sv
// Checks the adder {overflow,sum} stream against a model of two lock-stepped counters.
module sum_checker
    import sum_checker_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned LOSS_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     sum,
    input  logic                 overflow,
    output logic                 locked,
    output logic                 mismatch,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] chk_count,
    output logic [WIDTH:0]       first_err,
    output logic                 err_seen
);

    localparam int unsigned RunWidth = ($clog2(LOSS_LIMIT) < 1) ? 1 : $clog2(LOSS_LIMIT);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [RunWidth-1:0]   run_q, run_d;
    logic [WIDTH:0]        obs_q;
    logic                  mismatch_q;
    logic [WIDTH:0]        first_err_q;
    logic                  err_seen_q;
    logic                  obs_match;
    logic                  cmp_valid;
    logic                  cmp_err;

    // Zero-extended compare; upper bits are zero on both sides.
    assign obs_match = (expected_obs(32'(count_q)) == 33'(obs_q));

    // Next state, model count and consecutive-miss tracking.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        run_d     = run_q;
        cmp_valid = 1'b0;
        cmp_err   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StSync;
                end
            end
            StSync: begin
                // Odd samples cannot be 2*count; wait for an even one to derive the count.
                if (!obs_q[0]) begin
                    count_d = obs_q[WIDTH:1] + WIDTH'(1);
                    state_d = StLocked;
                end
            end
            StLocked: begin
                cmp_valid = 1'b1;
                count_d   = count_q + WIDTH'(1);
                if (obs_match) begin
                    run_d = '0;
                end else begin
                    cmp_err = 1'b1;
                    if (run_q == RunWidth'(LOSS_LIMIT - 1)) begin
                        run_d   = '0;
                        state_d = StSync;
                    end else begin
                        run_d = run_q + RunWidth'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Disable wins over every transition, but a compare made this cycle still counts.
        if (!enable) begin
            state_d = StIdle;
            run_d   = '0;
        end
    end

    // State, model, input stage and error capture registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            run_q       <= '0;
            obs_q       <= '0;
            mismatch_q  <= 1'b0;
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            run_q      <= run_d;
            obs_q      <= {overflow, sum};
            mismatch_q <= cmp_err;
            if (cmp_err && !err_seen_q) begin
                first_err_q <= obs_q;
                err_seen_q  <= 1'b1;
            end
        end
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cmp_err),
        .value (err_count)
    );

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_chk_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cmp_valid),
        .value (chk_count)
    );

    assign locked    = (state_q == StLocked);
    assign mismatch  = mismatch_q;
    assign first_err = first_err_q;
    assign err_seen  = err_seen_q;

endmodule

// File: tb/tb_sum_checker.sv
`timescale 1ns/1ps
// Directed bench for sum_checker: table-driven stream plus reset and saturation sequences.
module tb_sum_checker;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [7:0]  sum;
    logic        overflow;

    logic        locked, mismatch, err_seen;
    logic [15:0] err_count, chk_count;
    logic [8:0]  first_err;

    logic        s_locked, s_mismatch, s_err_seen;
    logic [3:0]  s_err_count, s_chk_count;
    logic [8:0]  s_first_err;

    int n_checks;
    int n_fail;

    sum_checker #(
        .WIDTH      (8),
        .CNT_WIDTH  (16),
        .LOSS_LIMIT (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sum       (sum),
        .overflow  (overflow),
        .locked    (locked),
        .mismatch  (mismatch),
        .err_count (err_count),
        .chk_count (chk_count),
        .first_err (first_err),
        .err_seen  (err_seen)
    );

    // Narrow statistics counters to exercise saturation.
    sum_checker #(
        .WIDTH      (8),
        .CNT_WIDTH  (4),
        .LOSS_LIMIT (4)
    ) u_small (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sum       (sum),
        .overflow  (overflow),
        .locked    (s_locked),
        .mismatch  (s_mismatch),
        .err_count (s_err_count),
        .chk_count (s_chk_count),
        .first_err (s_first_err),
        .err_seen  (s_err_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [8:0]  obs;
        logic        lk;
        logic        mm;
        logic [15:0] err;
        logic [15:0] chk;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic en, input logic [8:0] obs, input logic lk,
                                input logic mm, input int err, input int chk);
        vec_t v;
        v.en  = en;
        v.obs = obs;
        v.lk  = lk;
        v.mm  = mm;
        v.err = 16'(err);
        v.chk = 16'(chk);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one sample, cross the next rising edge, settle.
    task automatic step(input logic en, input logic [8:0] obs);
        enable   = en;
        overflow = obs[8];
        sum      = obs[7:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        enable   = 1'b0;
        sum      = '0;
        overflow = 1'b0;

        // Stream: lock, wrap points, single error, loss/relock, enable-drop on error, odd sync.
        add(1, 9'h000, 0, 0, 0, 0);
        add(1, 9'h002, 1, 0, 0, 0);
        add(1, 9'h004, 1, 0, 0, 1);
        add(1, 9'h006, 1, 0, 0, 2);
        add(1, 9'h008, 1, 0, 0, 3);
        add(1, 9'h00A, 1, 0, 0, 4);
        add(0, 9'h00C, 0, 0, 0, 5);
        add(1, 9'h0FC, 0, 0, 0, 5);
        add(1, 9'h0FE, 1, 0, 0, 5);
        add(1, 9'h100, 1, 0, 0, 6);
        add(1, 9'h102, 1, 0, 0, 7);
        add(1, 9'h104, 1, 0, 0, 8);
        add(1, 9'h106, 1, 0, 0, 9);
        add(0, 9'h108, 0, 0, 0, 10);
        add(1, 9'h1FC, 0, 0, 0, 10);
        add(1, 9'h1FE, 1, 0, 0, 10);
        add(1, 9'h000, 1, 0, 0, 11);
        add(1, 9'h002, 1, 0, 0, 12);
        add(1, 9'h004, 1, 0, 0, 13);
        add(1, 9'h006, 1, 0, 0, 14);
        add(1, 9'h008, 1, 0, 0, 15);
        add(1, 9'h00A, 1, 0, 0, 16);
        add(1, 9'h00C, 1, 0, 0, 17);
        add(1, 9'h00E, 1, 0, 0, 18);
        add(1, 9'h010, 1, 0, 0, 19);
        add(1, 9'h0FF, 1, 0, 0, 20);
        add(1, 9'h014, 1, 1, 1, 21);
        add(1, 9'h016, 1, 0, 1, 22);
        add(1, 9'h018, 1, 0, 1, 23);
        add(1, 9'h1AA, 1, 0, 1, 24);
        add(1, 9'h1AA, 1, 1, 2, 25);
        add(1, 9'h1AA, 1, 1, 3, 26);
        add(1, 9'h1AA, 1, 1, 4, 27);
        add(1, 9'h040, 0, 1, 5, 28);
        add(1, 9'h042, 1, 0, 5, 28);
        add(1, 9'h044, 1, 0, 5, 29);
        add(1, 9'h0EE, 1, 0, 5, 30);
        add(0, 9'h003, 0, 1, 6, 31);
        add(1, 9'h003, 0, 0, 6, 31);
        add(1, 9'h005, 0, 0, 6, 31);
        add(1, 9'h020, 0, 0, 6, 31);
        add(1, 9'h022, 1, 0, 6, 31);
        add(1, 9'h024, 1, 0, 6, 32);
        add(1, 9'h026, 1, 0, 6, 33);

        // Reset values before any edge.
        #1;
        check("rst_locked", 32'(locked), 0);
        check("rst_mismatch", 32'(mismatch), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_chk_count", 32'(chk_count), 0);
        check("rst_first_err", 32'(first_err), 0);
        check("rst_err_seen", 32'(err_seen), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].obs);
            check($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].lk));
            check($sformatf("vec%0d_mismatch", i), 32'(mismatch), 32'(vecs[i].mm));
            check($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(vecs[i].err));
            check($sformatf("vec%0d_chk_count", i), 32'(chk_count), 32'(vecs[i].chk));
        end
        check("first_err_held", 32'(first_err), 32'h0FF);
        check("err_seen_set", 32'(err_seen), 1);
        check("small_err_count", 32'(s_err_count), 6);
        check("small_chk_sat", 32'(s_chk_count), 15);

        // Async reset while locked: outputs clear without an edge.
        rst = 1'b0;
        #2;
        check("async_locked", 32'(locked), 0);
        check("async_mismatch", 32'(mismatch), 0);
        check("async_err_count", 32'(err_count), 0);
        check("async_chk_count", 32'(chk_count), 0);
        check("async_first_err", 32'(first_err), 0);
        check("async_err_seen", 32'(err_seen), 0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1, 9'h030);
        check("relock_sync", 32'(locked), 0);
        step(1, 9'h032);
        check("relock_locked", 32'(locked), 1);
        step(1, 9'h034);
        check("relock_chk", 32'(chk_count), 1);
        check("relock_err", 32'(err_count), 0);
        check("relock_seen", 32'(err_seen), 0);

        // Constant zero stream: lock, 4 misses, resync, repeat (4 misses per 5 cycles).
        enable = 1'b0;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 26; i++) begin
            step(1, 9'h000);
        end
        check("sat_big_err20", 32'(err_count), 20);
        check("sat_small_err15", 32'(s_err_count), 15);
        for (int i = 0; i < 10; i++) begin
            step(1, 9'h000);
        end
        check("sat_big_err28", 32'(err_count), 28);
        check("sat_big_chk28", 32'(chk_count), 28);
        check("sat_small_err_held", 32'(s_err_count), 15);
        check("sat_small_chk_held", 32'(s_chk_count), 15);
        check("sat_big_locked", 32'(locked), 0);
        check("sat_small_locked", 32'(s_locked), 0);
        check("sat_big_mismatch", 32'(mismatch), 1);
        check("sat_small_mismatch", 32'(s_mismatch), 1);
        check("sat_small_first_err", 32'(s_first_err), 0);
        check("sat_small_seen", 32'(s_err_seen), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
